// File: rtl/ram_cmd_ctrl.sv
// Command front-end for a single-port read-first RAM: clears the array after
// reset, then serialises valid/ready read/write commands into one response each.
module ram_cmd_ctrl #(
   parameter int                   addressWidth = 5,
   parameter int                   dataWidth    = 32,
   parameter logic [dataWidth-1:0] CLEAR_VALUE  = '0
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    cmd_valid,
   output logic                    cmd_ready,
   input  logic                    cmd_we,
   input  logic [addressWidth-1:0] cmd_addr,
   input  logic [dataWidth-1:0]    cmd_wdata,
   output logic                    rsp_valid,
   input  logic                    rsp_ready,
   output logic [dataWidth-1:0]    rsp_data,
   output logic [addressWidth-1:0] rsp_addr,
   output logic                    rsp_we,
   output logic                    init_done,
   output logic                    ram_en,
   output logic                    ram_we,
   output logic [addressWidth-1:0] ram_address,
   output logic [dataWidth-1:0]    ram_din,
   input  logic [dataWidth-1:0]    ram_dout
);

   typedef enum logic [1:0] {
      S_CLEAR,
      S_IDLE,
      S_CAPT,
      S_RESP
   } state_t;

   state_t                  state_q, state_d;
   logic [addressWidth-1:0] clr_cnt_q, clr_cnt_d;
   logic                    rsp_valid_q, rsp_valid_d;
   logic [dataWidth-1:0]    rsp_data_q, rsp_data_d;
   logic [addressWidth-1:0] rsp_addr_q, rsp_addr_d;
   logic                    rsp_we_q, rsp_we_d;
   logic                    init_done_q, init_done_d;
   logic [addressWidth-1:0] lat_addr_q, lat_addr_d;
   logic                    lat_we_q, lat_we_d;
   logic                    ram_en_c, ram_we_c;

   // NOTE: every signal written here gets a default first, so no path leaves
   // it unassigned and no latch is inferred.
   always_comb begin
      state_d     = state_q;
      clr_cnt_d   = clr_cnt_q;
      rsp_valid_d = rsp_valid_q;
      rsp_data_d  = rsp_data_q;
      rsp_addr_d  = rsp_addr_q;
      rsp_we_d    = rsp_we_q;
      init_done_d = init_done_q;
      lat_addr_d  = lat_addr_q;
      lat_we_d    = lat_we_q;
      cmd_ready   = 1'b0;
      ram_en_c    = 1'b0;
      ram_we_c    = 1'b0;
      ram_address = '0;
      ram_din     = '0;

      case (state_q)
         S_CLEAR: begin
            ram_en_c    = 1'b1;
            ram_we_c    = 1'b1;
            ram_address = clr_cnt_q;
            ram_din     = CLEAR_VALUE;
            clr_cnt_d   = clr_cnt_q + addressWidth'(1);
            if (&clr_cnt_q) begin
               state_d     = S_IDLE;
               init_done_d = 1'b1;
            end
         end
         S_IDLE: cmd_ready = 1'b1;
         S_CAPT: begin
            rsp_valid_d = 1'b1;
            rsp_data_d  = ram_dout;
            rsp_addr_d  = lat_addr_q;
            rsp_we_d    = lat_we_q;
            state_d     = S_RESP;
         end
         S_RESP: begin
            cmd_ready = rsp_ready;
            if (rsp_ready) begin
               rsp_valid_d = 1'b0;
               state_d     = S_IDLE;
            end
         end
         default: state_d = S_CLEAR;
      endcase

      // An accepted command overrides the IDLE/RESP defaults above.
      if (cmd_valid && cmd_ready) begin
         ram_en_c    = 1'b1;
         ram_we_c    = cmd_we;
         ram_address = cmd_addr;
         ram_din     = cmd_wdata;
         lat_addr_d  = cmd_addr;
         lat_we_d    = cmd_we;
         state_d     = S_CAPT;
      end
   end

   // Reset holds the state at CLEAR, so the RAM strobes are gated explicitly.
   assign ram_en = ram_en_c & ~rst;
   assign ram_we = ram_we_c & ~rst;

   // NOTE: state registers use non-blocking assignments so every flop samples
   // the pre-edge values regardless of statement order.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= S_CLEAR;
         clr_cnt_q   <= '0;
         rsp_valid_q <= 1'b0;
         rsp_data_q  <= '0;
         rsp_addr_q  <= '0;
         rsp_we_q    <= 1'b0;
         init_done_q <= 1'b0;
         lat_addr_q  <= '0;
         lat_we_q    <= 1'b0;
      end else begin
         state_q     <= state_d;
         clr_cnt_q   <= clr_cnt_d;
         rsp_valid_q <= rsp_valid_d;
         rsp_data_q  <= rsp_data_d;
         rsp_addr_q  <= rsp_addr_d;
         rsp_we_q    <= rsp_we_d;
         init_done_q <= init_done_d;
         lat_addr_q  <= lat_addr_d;
         lat_we_q    <= lat_we_d;
      end
   end

   assign rsp_valid = rsp_valid_q;
   assign rsp_data  = rsp_data_q;
   assign rsp_addr  = rsp_addr_q;
   assign rsp_we    = rsp_we_q;
   assign init_done = init_done_q;

endmodule

// File: tb/tb_ram_cmd_ctrl.sv
// Bench for ram_cmd_ctrl: a read-first RAM model on the ram_* port plus a
// word-level golden array predicting every response and the clear sweep.
module tb_ram_cmd_ctrl;

   localparam int AW    = 5;
   localparam int DW    = 32;
   localparam int DEPTH = 1 << AW;
   localparam logic [DW-1:0] CLR = '0;

   logic          clk, rst;
   logic          cmd_valid, cmd_ready, cmd_we;
   logic [AW-1:0] cmd_addr;
   logic [DW-1:0] cmd_wdata;
   logic          rsp_valid, rsp_ready, rsp_we;
   logic [DW-1:0] rsp_data;
   logic [AW-1:0] rsp_addr;
   logic          init_done;
   logic          ram_en, ram_we;
   logic [AW-1:0] ram_address;
   logic [DW-1:0] ram_din, ram_dout;

   ram_cmd_ctrl #(.addressWidth(AW), .dataWidth(DW), .CLEAR_VALUE(CLR)) dut (
      .clk(clk), .rst(rst),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_we(cmd_we),
      .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
      .rsp_addr(rsp_addr), .rsp_we(rsp_we), .init_done(init_done),
      .ram_en(ram_en), .ram_we(ram_we), .ram_address(ram_address),
      .ram_din(ram_din), .ram_dout(ram_dout)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Read-first single-port RAM, starting with garbage so the sweep matters.
   logic [DW-1:0] mem [DEPTH];
   initial begin
      for (int i = 0; i < DEPTH; i++) mem[i] = $urandom;
      ram_dout = $urandom;
   end
   always @(posedge clk) begin
      if (ram_en) begin
         ram_dout <= mem[ram_address];
         if (ram_we) mem[ram_address] <= ram_din;
      end
   end

   // Golden contents seen by the command stream.
   logic [DW-1:0] ref_mem [DEPTH];
   logic [DW-1:0] last_data;
   logic [AW-1:0] last_addr;
   logic          last_we;

   int pass_cnt  = 0;
   int total_cnt = 0;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total_cnt++;
      assert (obs === exp) pass_cnt++;
      else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_model();
      for (int i = 0; i < DEPTH; i++) ref_mem[i] = CLR;
   endtask

   // Called at posedge+1 right after reset release; walks all sweep cycles.
   task automatic sweep_check();
      for (int i = 0; i < DEPTH; i++) begin
         #1;
         check("sweep_en", ram_en, 1'b1);
         check("sweep_we", ram_we, 1'b1);
         check("sweep_addr", ram_address, i);
         check("sweep_din", ram_din, CLR);
         check("sweep_ready", cmd_ready, 1'b0);
         check("sweep_init", init_done, 1'b0);
         check("sweep_rsp", rsp_valid, 1'b0);
         tick();
      end
      check("init_done", init_done, 1'b1);
   endtask

   // One command with an optional response stall, checked against ref_mem.
   task automatic run_cmd(input logic we, input logic [AW-1:0] addr,
                          input logic [DW-1:0] wdata, input int stall);
      logic [DW-1:0] exp;
      int n;
      cmd_we = we; cmd_addr = addr; cmd_wdata = wdata; cmd_valid = 1'b1;
      rsp_ready = 1'b0;
      if (rsp_valid) begin
         for (int s = 0; s < stall; s++) begin
            #1;
            check("stall_ready", cmd_ready, 1'b0);
            check("stall_en", ram_en, 1'b0);
            check("stall_valid", rsp_valid, 1'b1);
            check("stall_data", rsp_data, last_data);
            check("stall_addr", rsp_addr, last_addr);
            check("stall_we", rsp_we, last_we);
            tick();
         end
      end
      rsp_ready = 1'b1;
      #1;
      n = 0;
      while (!cmd_ready && n < 8) begin
         tick();
         n++;
      end
      if (n == 8) check("accept_timeout", 1'b0, 1'b1);
      check("acc_en", ram_en, 1'b1);
      check("acc_we", ram_we, we);
      check("acc_addr", ram_address, addr);
      check("acc_din", ram_din, wdata);
      exp = ref_mem[addr];
      if (we) ref_mem[addr] = wdata;
      tick();
      rsp_ready = 1'b0;
      check("capt_valid", rsp_valid, 1'b0);
      check("capt_en", ram_en, 1'b0);
      tick();
      check("rsp_valid", rsp_valid, 1'b1);
      check("rsp_data", rsp_data, exp);
      check("rsp_addr", rsp_addr, addr);
      check("rsp_we", rsp_we, we);
      last_data = exp; last_addr = addr; last_we = we;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not complete within time limit");
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b1; cmd_valid = 1'b0; cmd_we = 1'b0; cmd_addr = '0;
      cmd_wdata = '0; rsp_ready = 1'b0;
      clear_model();
      tick(); tick();
      check("rst_en", ram_en, 1'b0);
      check("rst_we", ram_we, 1'b0);
      check("rst_valid", rsp_valid, 1'b0);
      check("rst_data", rsp_data, '0);
      check("rst_addr", rsp_addr, '0);
      check("rst_rwe", rsp_we, 1'b0);
      check("rst_init", init_done, 1'b0);
      check("rst_ready", cmd_ready, 1'b0);

      // A write waits through the whole sweep and must not be lost.
      cmd_valid = 1'b1; cmd_we = 1'b1; cmd_addr = 5'd3; cmd_wdata = 32'hDEADBEEF;
      rst = 1'b0;
      sweep_check();

      #1;
      check("w1_ready", cmd_ready, 1'b1);
      check("w1_en", ram_en, 1'b1);
      check("w1_we", ram_we, 1'b1);
      check("w1_addr", ram_address, 5'd3);
      check("w1_din", ram_din, 32'hDEADBEEF);
      tick();
      cmd_valid = 1'b0;
      check("w1_capt_valid", rsp_valid, 1'b0);
      tick();
      check("w1_valid", rsp_valid, 1'b1);
      check("w1_data", rsp_data, 32'h0);
      check("w1_addr_r", rsp_addr, 5'd3);
      check("w1_we_r", rsp_we, 1'b1);
      ref_mem[3] = 32'hDEADBEEF;

      // Read-back, retiring the previous response on the same edge.
      cmd_valid = 1'b1; cmd_we = 1'b0; cmd_addr = 5'd3; rsp_ready = 1'b1;
      #1;
      check("r1_ready", cmd_ready, 1'b1);
      check("r1_we", ram_we, 1'b0);
      tick();
      check("r1_retired", rsp_valid, 1'b0);
      tick();
      check("r1_data", rsp_data, 32'hDEADBEEF);
      check("r1_we_r", rsp_we, 1'b0);

      cmd_we = 1'b1; cmd_wdata = 32'h12345678;
      tick(); tick();
      check("w2_data", rsp_data, 32'hDEADBEEF);
      check("w2_we_r", rsp_we, 1'b1);
      ref_mem[3] = 32'h12345678;

      // Five cycles of back-pressure with a command pending.
      rsp_ready = 1'b0; cmd_we = 1'b0; cmd_addr = 5'd3;
      for (int s = 0; s < 5; s++) begin
         #1;
         check("hold_ready", cmd_ready, 1'b0);
         check("hold_en", ram_en, 1'b0);
         check("hold_valid", rsp_valid, 1'b1);
         check("hold_data", rsp_data, 32'hDEADBEEF);
         check("hold_addr", rsp_addr, 5'd3);
         check("hold_we", rsp_we, 1'b1);
         tick();
      end
      rsp_ready = 1'b1;
      #1;
      check("release_ready", cmd_ready, 1'b1);
      check("release_en", ram_en, 1'b1);
      tick();
      check("release_retired", rsp_valid, 1'b0);
      tick();
      check("release_data", rsp_data, 32'h12345678);

      // Back-to-back reads: one accept every second cycle.
      for (int i = 0; i < 4; i++) begin
         cmd_addr = AW'(i);
         #1;
         check("b2b_ready", cmd_ready, 1'b1);
         check("b2b_addr", ram_address, i);
         tick();
         check("b2b_capt_ready", cmd_ready, 1'b0);
         check("b2b_capt_en", ram_en, 1'b0);
         tick();
         check("b2b_valid", rsp_valid, 1'b1);
         check("b2b_rsp_addr", rsp_addr, i);
         check("b2b_data", rsp_data, ref_mem[i]);
      end
      last_data = ref_mem[3]; last_addr = 5'd3; last_we = 1'b0;

      // Randomised traffic with stalls and idle gaps.
      for (int k = 0; k < 60; k++) begin
         if ($urandom_range(0, 3) == 0) begin
            cmd_valid = 1'b0; rsp_ready = 1'b1;
            tick();
            check("gap_valid", rsp_valid, 1'b0);
            check("gap_ready", cmd_ready, 1'b1);
         end
         run_cmd(1'($urandom_range(0, 1)), AW'($urandom_range(0, DEPTH - 1)),
                 $urandom, $urandom_range(0, 3));
      end

      // Reset with a response outstanding, then again mid-sweep.
      cmd_valid = 1'b0; rsp_ready = 1'b0;
      rst = 1'b1;
      #1;
      check("mid_rst_valid", rsp_valid, 1'b0);
      check("mid_rst_en", ram_en, 1'b0);
      check("mid_rst_init", init_done, 1'b0);
      tick();
      rst = 1'b0;
      clear_model();
      for (int i = 0; i < 10; i++) tick();
      check("sweep10_addr", ram_address, 5'd10);
      rst = 1'b1;
      #1;
      check("sweep_rst_en", ram_en, 1'b0);
      check("sweep_rst_init", init_done, 1'b0);
      tick();
      rst = 1'b0;
      sweep_check();

      for (int k = 0; k < 4; k++)
         run_cmd(1'b0, AW'($urandom_range(0, DEPTH - 1)), '0, 0);

      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule
